main_memory_responder: RTL

Word-organised main-memory model that answers the cache controller's memory port as a fixed-latency responder. It accepts one word read or write per request and completes it exactly `LAG` cycles later. It signals completion with a one-cycle `ready` pulse, and holds read data until the next read completes. It sits below the cache controller, which drives `mem_addr`, `we_mem` and `mem_data_in` and samples `mem_data_out`; it also serves as the backing store for data-path simulation.

---
 rtl/main_memory_responder.sv | 90 +++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - fixed-latency word memory answering the cache controller's memory port
// Accepts one request at a time, completes it LAG edges later with a one-cycle ready pulse.
module main_memory_responder #(
    parameter int LAG        = 4,
    parameter int INDEX_BITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [0:3][7:0]  data_in,
    output logic [0:3][7:0]  data_out,
    output logic             ready,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    lat_we;
    logic [INDEX_BITS-1:0]   lat_idx;
    logic [0:3][7:0]         lat_data;
    logic                    done;

    // Contents are deliberately left out of reset so a simulation image survives rst.
    logic [0:3][7:0]         mem [0:(1<<INDEX_BITS)-1];

    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:INDEX_BITS+2], addr[1:0]};

    assign done = (state == S_WAIT) && (cnt == 4'(LAG));

    always_ff @(posedge clk) begin
        if (!rst && done && lat_we) begin
            mem[lat_idx] <= lat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            data_out <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        lat_we   <= we;
                        lat_idx  <= addr[INDEX_BITS+1:2];
                        lat_data <= data_in;
                        cnt      <= 4'd1;
                        busy     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Only one request may be in flight; extra strobes are dropped and flagged.
                    if (enable) begin
                        overrun <= 1'b1;
                    end
                    if (done) begin
                        if (!lat_we) begin
                            data_out <= mem[lat_idx];
                        end
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
